noise_gen: RTL and testbench

Parametrised APU noise channel: a pseudo-random LFSR voice with a 16-entry period table, envelope generator, length counter and selectable short/long feedback mode. It sits beside the rectangle channels in the APU and is driven by the shared `frame_counter` 240 Hz / 120 Hz enables and the same four-byte register file format. The output is a signed, width-configurable sample for the mixer.

---
 rtl/noise_gen.sv | 144 ++++++++++++++
 tb/tb_noise_gen.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/noise_gen.sv
// APU noise channel: LFSR voice with period table, envelope, length counter.
// Optional short-feedback mode is built only when NOISE_SHORT_MODE_EN is defined.
module noise_gen #(
  parameter int LFSR_W    = 15,
  parameter int LONG_TAP  = 1,
  parameter int SHORT_TAP = 6,
  parameter int OUT_W     = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             enable_240hz,
  input  logic             enable_120hz,
  input  logic [7:0]       reg_0,
  input  logic [7:0]       reg_2,
  input  logic [7:0]       reg_3,
  input  logic             reg_change,
  output logic [OUT_W-1:0] noise_out
);

  localparam int SHIFT = OUT_W - 5;

  logic              chg_q;
  logic              write_evt;
  logic [LFSR_W-1:0] lfsr;
  logic [10:0]       timer;
  logic [7:0]        length;
  logic [3:0]        decay;
  logic [3:0]        divider;
  logic              start;
  logic [10:0]       period;
  logic [7:0]        len_load;
  logic              fb;
  logic [3:0]        vol;
  logic [4:0]        sample;
  logic [OUT_W-1:0]  sample_ext;
  logic              unused_bits;

  assign write_evt = (reg_change != chg_q);

  always_comb begin
    period = 11'd2;
    case (reg_2[3:0])
      4'd0:  period = 11'd2;
      4'd1:  period = 11'd4;
      4'd2:  period = 11'd8;
      4'd3:  period = 11'd16;
      4'd4:  period = 11'd32;
      4'd5:  period = 11'd48;
      4'd6:  period = 11'd64;
      4'd7:  period = 11'd80;
      4'd8:  period = 11'd101;
      4'd9:  period = 11'd127;
      4'd10: period = 11'd190;
      4'd11: period = 11'd254;
      4'd12: period = 11'd381;
      4'd13: period = 11'd508;
      4'd14: period = 11'd1017;
      4'd15: period = 11'd2034;
      default: period = 11'd2;
    endcase
  end

  always_comb begin
    len_load = 8'd10;
    case (reg_3[7:3])
      5'd0:  len_load = 8'd10;   5'd1:  len_load = 8'd254;
      5'd2:  len_load = 8'd20;   5'd3:  len_load = 8'd2;
      5'd4:  len_load = 8'd40;   5'd5:  len_load = 8'd4;
      5'd6:  len_load = 8'd80;   5'd7:  len_load = 8'd6;
      5'd8:  len_load = 8'd160;  5'd9:  len_load = 8'd8;
      5'd10: len_load = 8'd60;   5'd11: len_load = 8'd10;
      5'd12: len_load = 8'd14;   5'd13: len_load = 8'd12;
      5'd14: len_load = 8'd26;   5'd15: len_load = 8'd14;
      5'd16: len_load = 8'd12;   5'd17: len_load = 8'd16;
      5'd18: len_load = 8'd24;   5'd19: len_load = 8'd18;
      5'd20: len_load = 8'd48;   5'd21: len_load = 8'd20;
      5'd22: len_load = 8'd96;   5'd23: len_load = 8'd22;
      5'd24: len_load = 8'd192;  5'd25: len_load = 8'd24;
      5'd26: len_load = 8'd72;   5'd27: len_load = 8'd26;
      5'd28: len_load = 8'd16;   5'd29: len_load = 8'd28;
      5'd30: len_load = 8'd32;   5'd31: len_load = 8'd30;
      default: len_load = 8'd10;
    endcase
  end

`ifdef NOISE_SHORT_MODE_EN
  assign fb = lfsr[0] ^ (reg_2[7] ? lfsr[SHORT_TAP] : lfsr[LONG_TAP]);
  assign unused_bits = ^{reg_0[7:6], reg_2[6:4], reg_3[2:0]};
`else
  assign fb = lfsr[0] ^ lfsr[LONG_TAP];
  assign unused_bits = ^{reg_0[7:6], reg_2[7:4], reg_3[2:0], lfsr[SHORT_TAP]};
`endif

  // Five-bit signed sample (+/-vol), sign-extended then scaled to OUT_W.
  assign vol        = reg_0[4] ? reg_0[3:0] : decay;
  assign sample     = lfsr[0] ? 5'(-{1'b0, vol}) : {1'b0, vol};
  assign sample_ext = OUT_W'($signed(sample));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      chg_q     <= reg_change;
      lfsr      <= LFSR_W'(1);
      timer     <= '0;
      length    <= '0;
      decay     <= '0;
      divider   <= '0;
      start     <= 1'b0;
      noise_out <= '0;
    end else begin
      chg_q <= reg_change;

      if (timer == '0) begin
        timer <= period - 11'd1;
        lfsr  <= (lfsr == '0) ? LFSR_W'(1) : {fb, lfsr[LFSR_W-1:1]};
      end else begin
        timer <= timer - 11'd1;
      end

      if (write_evt)
        length <= len_load;
      else if (enable_120hz && length != '0 && !reg_0[5])
        length <= length - 8'd1;

      if (enable_240hz) begin
        if (start) begin
          start   <= 1'b0;
          decay   <= 4'd15;
          divider <= reg_0[3:0];
        end else if (divider == '0) begin
          divider <= reg_0[3:0];
          if (decay != '0)  decay <= decay - 4'd1;
          else if (reg_0[5]) decay <= 4'd15;
        end else begin
          divider <= divider - 4'd1;
        end
      end
      // Placed after the tick handling so a coincident write re-arms the flag.
      if (write_evt) start <= 1'b1;

      noise_out <= (length == '0) ? '0 : (sample_ext << SHIFT);
    end
  end

endmodule

// File: tb/tb_noise_gen.sv
// Self-checking bench for noise_gen: cycle scoreboard on noise_out plus
// directed checks of reset, length, envelope, short-mode period and mid-run reset.
module tb_noise_gen;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        enable_240hz;
  logic        enable_120hz;
  logic [7:0]  reg_0;
  logic [7:0]  reg_2;
  logic [7:0]  reg_3;
  logic        reg_change;
  logic [15:0] noise_out;

  int n_tests = 0;
  int n_fail  = 0;

  logic [15:0] exp_q[$];

  localparam int PERIODS[16] = '{2, 4, 8, 16, 32, 48, 64, 80,
                                 101, 127, 190, 254, 381, 508, 1017, 2034};
  localparam int LENS[32] = '{10, 254, 20, 2, 40, 4, 80, 6, 160, 8, 60, 10, 14, 12, 26, 14,
                              12, 16, 24, 18, 48, 20, 96, 22, 192, 24, 72, 26, 16, 28, 32, 30};

  // reference model state
  logic [14:0] m_lfsr;
  int          m_timer, m_len, m_decay, m_div;
  bit          m_start, m_chg;

  noise_gen dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .enable_240hz (enable_240hz),
    .enable_120hz (enable_120hz),
    .reg_0        (reg_0),
    .reg_2        (reg_2),
    .reg_3        (reg_3),
    .reg_change   (reg_change),
    .noise_out    (noise_out)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- checking ----------------
  task automatic check_val(string tag, logic [31:0] got, logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t", tag, got, got, exp, exp, $time);
    end
  endtask

  function automatic int mag(logic [15:0] x);
    int s;
    s = int'($signed(x));
    if (s < 0) s = -s;
    return s / 2048;
  endfunction

  // ---------------- reference model ----------------
  function automatic logic [14:0] lfsr_next(logic [14:0] s, bit short_m);
    logic b;
    if (s == 15'd0) return 15'd1;
    b = s[0] ^ (short_m ? s[6] : s[1]);
    return {b, s[14:1]};
  endfunction

  task automatic model_step();
    logic [15:0] e;
    int  v, vol;
    bit  wr, short_m;
    vol = reg_0[4] ? int'(reg_0[3:0]) : m_decay;
    if (m_len == 0) e = 16'd0;
    else begin
      v = m_lfsr[0] ? -vol : vol;
      e = 16'(v * 2048);
    end
    if (!rst_n) begin
      m_lfsr = 15'd1; m_timer = 0; m_len = 0; m_decay = 0; m_div = 0;
      m_start = 0; m_chg = reg_change; e = 16'd0;
    end else begin
`ifdef NOISE_SHORT_MODE_EN
      short_m = reg_2[7];
`else
      short_m = 1'b0;
`endif
      wr = (reg_change != m_chg);
      m_chg = reg_change;
      if (m_timer == 0) begin
        m_timer = PERIODS[reg_2[3:0]] - 1;
        m_lfsr  = lfsr_next(m_lfsr, short_m);
      end else m_timer--;
      if (wr) m_len = LENS[reg_3[7:3]];
      else if (enable_120hz && m_len > 0 && !reg_0[5]) m_len--;
      if (enable_240hz) begin
        if (m_start) begin
          m_start = 0; m_decay = 15; m_div = reg_0[3:0];
        end else if (m_div == 0) begin
          m_div = reg_0[3:0];
          if (m_decay > 0) m_decay--;
          else if (reg_0[5]) m_decay = 15;
        end else m_div--;
      end
      if (wr) m_start = 1;
    end
    exp_q.push_back(e);
  endtask

  initial forever begin
    @(posedge clk);
    model_step();
  end

  // ---------------- scoreboard ----------------
  initial forever begin
    @(negedge clk);
    if (exp_q.size() > 0) check_val("sb_out", noise_out, exp_q.pop_front());
  end

  // ---------------- drivers ----------------
  // Called at a negedge: drives one cycle of inputs, returns at the next negedge.
  task automatic step(bit t120, bit t240, bit wr);
    enable_120hz = t120;
    enable_240hz = t240;
    if (wr) reg_change = ~reg_change;
    @(negedge clk);
    enable_120hz = 1'b0;
    enable_240hz = 1'b0;
  endtask

  task automatic idle(int n);
    repeat (n) step(1'b0, 1'b0, 1'b0);
  endtask

  task automatic do_reset(int n);
    rst_n = 1'b0;
    idle(n);
    rst_n = 1'b1;
  endtask

  // ---------------- stimulus ----------------
  bit rec[600];
  int diffs;

  initial begin
    rst_n = 1'b0; enable_120hz = 1'b0; enable_240hz = 1'b0;
    reg_0 = 8'h00; reg_2 = 8'h00; reg_3 = 8'h00; reg_change = 1'b1;
    @(negedge clk);

    // reset with random registers and ticks, reg_change held high
    repeat (4) begin
      reg_0 = 8'($urandom_range(0, 255));
      reg_2 = 8'($urandom_range(0, 255));
      reg_3 = 8'($urandom_range(0, 255));
      step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b0);
    end
    rst_n = 1'b1;
    reg_0 = 8'h1F; reg_2 = 8'h00; reg_3 = 8'h08;
    check_val("rst_out", noise_out, 16'd0);
    for (int i = 0; i < 5; i++) begin
      idle(1);
      check_val("rst_nowrite", noise_out, 16'd0);
    end

    // long mode, period 2, constant volume 15
    step(1'b0, 1'b0, 1'b1);
    idle(1);
    for (int i = 0; i < 40; i++) begin
      idle(1);
      if (i % 8 == 0) check_val("long_mag", mag(noise_out), 15);
    end

    // short-mode sequence period from seed 1
    reg_2 = 8'h80;
    do_reset(2);
    step(1'b0, 1'b0, 1'b1);
    idle(2);
    for (int i = 0; i < 600; i++) begin
      rec[i] = noise_out[15];
      idle(1);
    end
    diffs = 0;
    for (int i = 0; i < 400; i++) if (rec[i] != rec[i + 186]) diffs++;
`ifdef NOISE_SHORT_MODE_EN
    check_val("short_period93", diffs, 0);
`else
    check_val("long_not93", 32'(diffs != 0), 1);
`endif
    reg_2 = 8'h00;

    // length counter: mute exactly at the 254th pulse
    reg_0 = 8'h1F; reg_3 = 8'h08;
    step(1'b0, 1'b0, 1'b1);
    for (int t = 1; t <= 253; t++) begin
      step(1'b1, 1'b0, 1'b0);
      idle($urandom_range(0, 2));
    end
    idle(1);
    check_val("len_253_live", 32'(noise_out != 16'd0), 1);
    step(1'b1, 1'b0, 1'b0);
    idle(1);
    check_val("len_254_mute", noise_out, 16'd0);

    // halted length never mutes
    reg_0 = 8'h3F;
    step(1'b0, 1'b0, 1'b1);
    for (int t = 0; t < 300; t++) step(1'b1, 1'b0, 1'b0);
    idle(1);
    check_val("len_halt_live", 32'(noise_out != 16'd0), 1);

    // write coincident with 120 Hz tick reloads to 254
    reg_0 = 8'h1F;
    step(1'b1, 1'b0, 1'b1);
    for (int t = 1; t <= 253; t++) step(1'b1, 1'b0, 1'b0);
    idle(1);
    check_val("len_coinc_253", 32'(noise_out != 16'd0), 1);
    step(1'b1, 1'b0, 1'b0);
    idle(1);
    check_val("len_coinc_254", noise_out, 16'd0);

    // envelope, divider period 3, no loop
    reg_0 = 8'h03; reg_3 = 8'h08;
    step(1'b0, 1'b0, 1'b1);
    for (int t = 1; t <= 64; t++) begin
      step(1'b0, 1'b1, 1'b0);
      idle(1);
      if (t == 1)  check_val("env_t1", mag(noise_out), 15);
      if (t == 5)  check_val("env_t5", mag(noise_out), 14);
      if (t == 61) check_val("env_t61", mag(noise_out), 0);
      if (t == 64) check_val("env_t64", mag(noise_out), 0);
      idle($urandom_range(0, 2));
    end

    // envelope with loop: reloads to 15 on the decrement after reaching 0
    reg_0 = 8'h23;
    step(1'b0, 1'b0, 1'b1);
    for (int t = 1; t <= 65; t++) begin
      step(1'b0, 1'b1, 1'b0);
      idle(1);
      if (t == 1)  check_val("envl_t1", mag(noise_out), 15);
      if (t == 61) check_val("envl_t61", mag(noise_out), 0);
      if (t == 65) check_val("envl_t65", mag(noise_out), 15);
    end

    // random traffic, checked by the scoreboard
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 63) == 0) begin
        reg_0 = 8'($urandom_range(0, 255));
        reg_2 = 8'($urandom_range(0, 255)) & 8'h83;
        reg_3 = 8'($urandom_range(0, 255));
      end
      step(1'($urandom_range(0, 7) == 0), 1'($urandom_range(0, 7) == 0),
           1'($urandom_range(0, 99) == 0));
    end

    // mid-run reset while length is 100
    reg_0 = 8'h1F; reg_2 = 8'h00; reg_3 = 8'h08;
    step(1'b0, 1'b0, 1'b1);
    for (int t = 0; t < 154; t++) step(1'b1, 1'b0, 1'b0);
    idle(1);
    check_val("mrst_pre", 32'(noise_out != 16'd0), 1);
    rst_n = 1'b0;
    step(1'b1, 1'b1, 1'b0);
    rst_n = 1'b1;
    check_val("mrst_out", noise_out, 16'd0);
    idle(1);
    check_val("mrst_len", noise_out, 16'd0);
    idle(3);
    check_val("mrst_stay", noise_out, 16'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
